// File: rtl/rom_seq_pkg.sv
// rtl/rom_seq_pkg.sv - shared widths, FSM state type and step-count helper for the ROM program sequencer
package rom_seq_pkg;

    localparam int STEP_W  = 5;
    localparam int DATA_W  = 32;
    localparam int ROM1_AW = 5;
    localparam int ROMQ_AW = 2;
    localparam int ROM6_AW = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        OUTPUT = 2'd2,
        DONE   = 2'd3
    } state_e;

    // A count of zero asks for a full sweep of the step space.
    function automatic logic [STEP_W:0] steps_of(input logic [STEP_W-1:0] count);
        if (count == '0) begin
            return (STEP_W+1)'(1 << STEP_W);
        end
        return {1'b0, count};
    endfunction

endpackage

// File: rtl/rom_program_sequencer_if.sv
// rtl/rom_program_sequencer_if.sv - host, ROM address, datapath and result-stream signals of the sequencer
interface rom_program_sequencer_if;
    import rom_seq_pkg::*;

    logic                start;
    logic [STEP_W-1:0]   base;
    logic [STEP_W-1:0]   count;
    logic                busy;
    logic                done;

    logic [ROM1_AW-1:0]  addr_rom1;
    logic [ROMQ_AW-1:0]  addr_rom2;
    logic [ROMQ_AW-1:0]  addr_rom3;
    logic [ROMQ_AW-1:0]  addr_rom4;
    logic [ROMQ_AW-1:0]  addr_rom5;
    logic [ROM6_AW-1:0]  addr_rom6;
    logic [DATA_W-1:0]   dp_result;

    logic                out_valid;
    logic                out_ready;
    logic [DATA_W-1:0]   out_data;
    logic                out_last;

    modport master (
        input  start, base, count, dp_result, out_ready,
        output busy, done,
        output addr_rom1, addr_rom2, addr_rom3, addr_rom4, addr_rom5, addr_rom6,
        output out_valid, out_data, out_last
    );

    modport slave (
        output start, base, count, dp_result, out_ready,
        input  busy, done,
        input  addr_rom1, addr_rom2, addr_rom3, addr_rom4, addr_rom5, addr_rom6,
        input  out_valid, out_data, out_last
    );

endinterface

// File: rtl/rom_step_counter.sv
// rtl/rom_step_counter.sv - step index, wrapped step address register and last-step flag
module rom_step_counter
    import rom_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              advance,
    input  logic [STEP_W-1:0] base,
    input  logic [STEP_W-1:0] count,
    output logic [STEP_W-1:0] step_addr,
    output logic              last
);

    localparam logic [STEP_W:0] ONE = (STEP_W+1)'(1);

    logic [STEP_W-1:0] base_q, base_d;
    logic [STEP_W:0]   n_q,    n_d;
    logic [STEP_W-1:0] k_q,    k_d;
    logic [STEP_W-1:0] addr_q, addr_d;

    // The address is registered from the next-k value so it changes on the same edge as k.
    always_comb begin
        base_d = base_q;
        n_d    = n_q;
        k_d    = k_q;
        addr_d = addr_q;
        if (load) begin
            base_d = base;
            n_d    = steps_of(count);
            k_d    = '0;
            addr_d = base;
        end else if (advance) begin
            k_d    = k_q + STEP_W'(1);
            addr_d = base_q + k_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q <= '0;
            n_q    <= '0;
            k_q    <= '0;
            addr_q <= '0;
        end else begin
            base_q <= base_d;
            n_q    <= n_d;
            k_q    <= k_d;
            addr_q <= addr_d;
        end
    end

    assign step_addr = addr_q;
    assign last      = ({1'b0, k_q} == (n_q - ONE));

endmodule

// File: rtl/rom_program_sequencer.sv
// rtl/rom_program_sequencer.sv - walks ROM step addresses, waits for the datapath to settle and streams results
module rom_program_sequencer
    import rom_seq_pkg::*;
#(
    parameter int SETTLE_CYC = 1
)(
    input  logic                     clk,
    input  logic                     rst_n,
    rom_program_sequencer_if.master  bus
);

    localparam int            SW          = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);

    state_e              state_q,  state_d;
    logic [SW-1:0]       settle_q, settle_d;
    logic [DATA_W-1:0]   data_q,   data_d;
    logic                valid_q,  valid_d;
    logic                last_q,   last_d;
    logic                busy_q,   busy_d;
    logic                done_q,   done_d;

    logic                load;
    logic                advance;
    logic [STEP_W-1:0]   step_addr;
    logic                step_last;

    rom_step_counter u_step (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .advance   (advance),
        .base      (bus.base),
        .count     (bus.count),
        .step_addr (step_addr),
        .last      (step_last)
    );

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        data_d   = data_q;
        valid_d  = valid_q;
        last_d   = last_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        load     = 1'b0;
        advance  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    load     = 1'b1;
                    busy_d   = 1'b1;
                    settle_d = '0;
                    state_d  = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_q == SETTLE_LAST) begin
                    settle_d = '0;
                    data_d   = bus.dp_result;
                    valid_d  = 1'b1;
                    last_d   = step_last;
                    state_d  = OUTPUT;
                end else begin
                    settle_d = settle_q + SW'(1);
                end
            end
            OUTPUT: begin
                // Result and address are frozen until the beat is taken.
                if (bus.out_ready) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    if (last_q) begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        advance = 1'b1;
                        state_d = SETTLE;
                    end
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            settle_q <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign bus.out_last  = last_q;

    assign bus.addr_rom1 = step_addr;
    assign bus.addr_rom2 = step_addr[ROMQ_AW-1:0];
    assign bus.addr_rom3 = step_addr[ROMQ_AW-1:0];
    assign bus.addr_rom4 = step_addr[ROMQ_AW-1:0];
    assign bus.addr_rom5 = step_addr[ROMQ_AW-1:0];
    assign bus.addr_rom6 = step_addr[ROM6_AW-1:0];

endmodule
